// File: rtl/serial_operand_shifter.sv
// serial_operand_shifter
//
// Captures a parallel operand pair (I1, I2) and a carry-in, then presents them
// to a bit-serial adder one bit per cycle, LSB first. The operation runs for
// WIDTH bit cycles and is followed by a one-cycle done pulse before the block
// returns to idle. A downstream stall freezes the stream in place.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   operand pair and carry-in presented (sampled in IDLE only)
//   in_ready   block accepts a new operand pair this cycle
//   I1, I2     parallel operands A and B
//   cin_in     carry-in for the operation
//   stall      downstream hold request (honoured in SHIFT only)
//   a, b       current serial bits of A and B
//   cin        carry-in to the serial adder, valid on bit 0 only
//   bit_valid  a, b and cin are meaningful this cycle
//   first      current bit is bit 0
//   last       current bit is bit WIDTH-1
//   done       one-cycle pulse after the last bit is consumed

module serial_operand_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic             cin_in,
    input  logic             stall,
    output logic             a,
    output logic             b,
    output logic             cin,
    output logic             bit_valid,
    output logic             first,
    output logic             last,
    output logic             done
);

    // A one-bit counter still exists for WIDTH=1 so first/last have a source.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             c_reg;
    logic             at_first;
    logic             at_last;
    logic             accept;
    logic             advance;

    assign at_first = (cnt == '0);
    assign at_last  = (cnt == LAST_CNT);

    // NOTE: every register uses non-blocking assignment so all state updates
    // at an edge see the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        cin       = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bit_valid = 1'b1;
                a         = a_reg[0];
                b         = b_reg[0];
                cin       = c_reg & at_first;
                first     = at_first;
                last      = at_last;
                advance   = !stall;
                if (!stall && at_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand datapath. On the final bit the counter is left at WIDTH-1
    // rather than wrapping; the next accept clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            a_reg <= I1;
            b_reg <= I2;
            c_reg <= cin_in;
        end else if (advance) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            if (!at_last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_operand_shifter.sv
// Testbench for serial_operand_shifter.
// A queue-of-beats reference model predicts every cycle's outputs for the
// WIDTH=8 instance; a WIDTH=1 instance is checked against fixed values.

module tb_serial_operand_shifter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_in;
    logic             stall;
    logic             a, b, cin, bit_valid, first, last, done;

    logic             v1, ready1, a1_in, b1_in, c1_in, stall1;
    logic             a1, b1, cin1, bv1, first1, last1, done1;

    always #5 clk = ~clk;

    serial_operand_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .I1        (op_a),
        .I2        (op_b),
        .cin_in    (cin_in),
        .stall     (stall),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .bit_valid (bit_valid),
        .first     (first),
        .last      (last),
        .done      (done)
    );

    serial_operand_shifter #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v1),
        .in_ready  (ready1),
        .I1        (a1_in),
        .I2        (b1_in),
        .cin_in    (c1_in),
        .stall     (stall1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .bit_valid (bv1),
        .first     (first1),
        .last      (last1),
        .done      (done1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // One entry per serial bit still to be presented; done_pend marks the
    // single done cycle that follows the last bit.
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic f;
        logic l;
    } beat_t;

    beat_t q[$];
    bit    done_pend = 0;

    task automatic model_edge();
        if (!reset) begin
            q.delete();
            done_pend = 0;
        end else if (q.size() > 0) begin
            if (!stall) begin
                void'(q.pop_front());
                if (q.size() == 0) done_pend = 1;
            end
        end else if (done_pend) begin
            done_pend = 0;
        end else if (in_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
                beat_t bt;
                bt.a = op_a[i];
                bt.b = op_b[i];
                bt.c = (i == 0) ? cin_in : 1'b0;
                bt.f = (i == 0);
                bt.l = (i == WIDTH - 1);
                q.push_back(bt);
            end
        end
    endtask

    // {in_ready, bit_valid, a, b, cin, first, last, done}
    function automatic logic [7:0] model_out();
        if (q.size() > 0)
            return {1'b0, 1'b1, q[0].a, q[0].b, q[0].c, q[0].f, q[0].l, 1'b0};
        else if (done_pend)
            return 8'b0000_0001;
        else
            return 8'b1000_0000;
    endfunction

    function automatic logic [7:0] dut_out();
        return {in_ready, bit_valid, a, b, cin, first, last, done};
    endfunction

    function automatic logic [7:0] dut1_out();
        return {ready1, bv1, a1, b1, cin1, first1, last1, done1};
    endfunction

    int accepts[$];

    // One clock: advance the model on the edge, then compare away from it.
    task automatic step(input string tag);
        if (reset && in_ready && in_valid) accepts.push_back(cyc);
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check(tag, 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic present(input logic [7:0] x, input logic [7:0] y, input logic c);
        op_a     = x;
        op_b     = y;
        cin_in   = c;
        in_valid = 1'b1;
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        q.delete();
        done_pend = 0;
        check({tag, "_async"}, 32'(dut_out()), 32'(model_out()));
        step({tag, "_held"});
        #2 reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        cin_in   = 1'b0;
        stall    = 1'b0;
        v1 = 0; a1_in = 0; b1_in = 0; c1_in = 0; stall1 = 0;

        #1;
        check("reset_state", 32'(dut_out()), 32'(model_out()));
        check("reset_state_w1", 32'(dut1_out()), 32'h80);
        step("reset_edge");
        step("reset_edge");
        #2 reset = 1'b1;
        step("post_reset");

        // Basic operation, no stall.
        present(8'h31, 8'h14, 1'b1);
        step("basic");
        in_valid = 1'b0;
        repeat (11) step("basic");

        // Stall three edges while bit 3 is on the line.
        present(8'h31, 8'h14, 1'b1);
        step("stall");
        in_valid = 1'b0;
        repeat (3) step("stall");
        stall = 1'b1;
        repeat (3) step("stall_hold");
        stall = 1'b0;
        repeat (8) step("stall");

        // Reset mid-operation during bit 5, then a fresh operation.
        present(8'h31, 8'h14, 1'b1);
        step("abort");
        in_valid = 1'b0;
        repeat (5) step("abort");
        pulse_reset("abort_rst");
        step("abort_after");
        check("abort_no_done", 32'(done), 32'd0);
        present(8'hFF, 8'h01, 1'b0);
        step("fresh");
        in_valid = 1'b0;
        repeat (10) step("fresh");

        // in_valid held during SHIFT must not disturb the running stream.
        present(8'h31, 8'h14, 1'b1);
        step("ignore");
        op_a = 8'hAA;
        op_b = 8'h00;
        repeat (22) step("ignore");
        in_valid = 1'b0;
        repeat (3) step("ignore");

        // Back-to-back accepts with stall never asserted.
        accepts.delete();
        in_valid = 1'b1;
        repeat (45) step("b2b");
        in_valid = 1'b0;
        repeat (3) step("b2b");
        check("b2b_count", 32'(accepts.size() >= 4), 32'd1);
        for (int i = 1; i < accepts.size(); i++)
            check("b2b_spacing", 32'(accepts[i] - accepts[i-1]), 32'(WIDTH + 2));

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            op_a     = 8'($urandom);
            op_b     = 8'($urandom);
            cin_in   = 1'($urandom);
            in_valid = ($urandom_range(0, 2) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) pulse_reset("rand_rst");
            else step("rand");
        end
        in_valid = 1'b0;
        stall    = 1'b0;
        repeat (20) step("drain");

        // WIDTH=1 instance: single bit, then done, then ready.
        v1 = 1; a1_in = 1; b1_in = 1; c1_in = 1;
        step("w1_accept");
        check("w1_bit", 32'(dut1_out()), 32'b0111_1110);
        v1 = 0;
        step("w1_done");
        check("w1_done", 32'(dut1_out()), 32'b0000_0001);
        step("w1_idle");
        check("w1_idle", 32'(dut1_out()), 32'b1000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
